seg_scan_display: RTL and testbench

- Parametrised multiplexed 7-segment scanner for the calculator front panel; successor to the fixed 8-digit draw path.
- Holds a DIGITS-entry buffer, each entry a 4-bit hex code plus blank flag plus decimal point.
- Scans one digit per SCAN_DIV clocks and drives registered segment and one-hot digit-select outputs.
- Buffer fed by indexed writes, calculator-style shift-in pushes, or a bulk clear.

---
 rtl/seg_scan_pkg.sv | 28 ++
 rtl/seg_scan_if.sv | 23 ++
 rtl/seg_hex_decoder.sv | 11 +
 rtl/seg_scan_display.sv | 135 +++++++++++++
 tb/tb_seg_scan_display.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the multiplexed 7-segment scanner:
// segment bit positions, the hex glyph table and the buffer entry layout.
package seg_scan_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  typedef struct packed {
    logic       blank;
    logic       dp;
    logic [3:0] value;
  } digit_t;

  localparam digit_t BLANK_DIGIT = '{blank: 1'b1, dp: 1'b0, value: 4'h0};

  // Active-high {g,f,e,d,c,b,a}; index 15 first so GLYPH_TABLE[v] is glyph v.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg_scan_if.sv
// Buffer-update bus of the scanner: indexed write, shift-in push and bulk clear.
interface seg_scan_if #(
  parameter int DIGITS = 8
);
  localparam int IDX_W = $clog2(DIGITS);

  logic             wr_en;
  logic [IDX_W-1:0] wr_index;
  logic [3:0]       wr_value;
  logic             wr_dp;
  logic             push_en;
  logic [3:0]       push_value;
  logic             clr_buf;

  modport master (
    output wr_en, wr_index, wr_value, wr_dp, push_en, push_value, clr_buf
  );

  modport slave (
    input  wr_en, wr_index, wr_value, wr_dp, push_en, push_value, clr_buf
  );

endinterface

// File: rtl/seg_hex_decoder.sv
// Combinational hex to 7-segment decoder, active-high {g,f,e,d,c,b,a}.
module seg_hex_decoder
  import seg_scan_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] segs
);

  assign segs = GLYPH_TABLE[value];

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment scanner with a DIGITS-entry display buffer.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan_display
  import seg_scan_pkg::*;
#(
  parameter int DIGITS         = 8,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYCLES   = 4,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              clear_n,
  seg_scan_if.slave         bus,
  input  logic              blank_en,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] sel,
  output logic              frame_done
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam int PRE_W = $clog2(SCAN_DIV);

  localparam logic [7:0]        SEG_INV = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] SEL_INV = (SEL_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : '0;

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  digit_t            digits_q [DIGITS];
  digit_t            digits_d [DIGITS];
  logic [7:0]        seg_q, seg_d;
  logic [DIGITS-1:0] sel_q, sel_d;
  logic              frame_done_q, frame_done_d;

  logic              pre_wrap;
  digit_t            cur_digit;
  logic [6:0]        glyph;
  logic [7:0]        seg_on;
  logic [DIGITS-1:0] sel_on;
  logic              lz_blank;

  assign cur_digit = digits_q[idx_q];

  seg_hex_decoder u_dec (
    .value (cur_digit.value),
    .segs  (glyph)
  );

  // Scan timing: prescaler wraps every SCAN_DIV clocks and steps the digit index.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    pre_wrap     = (pre_q == PRE_W'(SCAN_DIV - 1));
    pre_d        = pre_wrap ? '0 : pre_q + PRE_W'(1);
    idx_d        = idx_q;
    frame_done_d = 1'b0;
    if (pre_wrap) begin
      if (idx_q == IDX_W'(DIGITS - 1)) begin
        idx_d        = '0;
        frame_done_d = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // Buffer update: clear beats push, push beats indexed write.
  always_comb begin
    for (int i = 0; i < DIGITS; i++) digits_d[i] = digits_q[i];
    if (bus.clr_buf) begin
      for (int i = 0; i < DIGITS; i++) digits_d[i] = BLANK_DIGIT;
    end else if (bus.push_en) begin
      for (int i = DIGITS - 1; i >= 1; i--) digits_d[i] = digits_q[i-1];
      digits_d[0] = '{blank: 1'b0, dp: 1'b0, value: bus.push_value};
    end else if (bus.wr_en && ({1'b0, bus.wr_index} < (IDX_W + 1)'(DIGITS))) begin
      digits_d[bus.wr_index] = '{blank: 1'b0, dp: bus.wr_dp, value: bus.wr_value};
    end
  end

`ifdef SEG_SCAN_LZB_EN
  // A zero is leading when it and every higher digit is blank or a plain zero.
  always_comb begin
    lz_blank = (idx_q != '0);
    for (int j = 0; j < DIGITS; j++) begin
      if (j >= int'(idx_q) && !digits_q[j].blank &&
          (digits_q[j].value != 4'h0 || digits_q[j].dp)) begin
        lz_blank = 1'b0;
      end
    end
  end
`else
  assign lz_blank = 1'b0;
`endif

  always_comb begin
    seg_on              = '0;
    seg_on[SEG_DP]      = cur_digit.dp;
    seg_on[SEG_G:SEG_A] = glyph;
    if (cur_digit.blank || blank_en || lz_blank) seg_on = '0;
    sel_on = {{(DIGITS-1){1'b0}}, 1'b1} << idx_q;

    // Anti-ghosting: lines stay off for the first BLANK_CYCLES of each slot.
    if (pre_q >= PRE_W'(BLANK_CYCLES)) begin
      seg_d = seg_on ^ SEG_INV;
      sel_d = sel_on ^ SEL_INV;
    end else begin
      seg_d = SEG_INV;
      sel_d = SEL_INV;
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      pre_q        <= '0;
      idx_q        <= '0;
      seg_q        <= SEG_INV;
      sel_q        <= SEL_INV;
      frame_done_q <= 1'b0;
      // NOTE: the buffer is small register storage, not a RAM, so it is reset to blank.
      for (int i = 0; i < DIGITS; i++) digits_q[i] <= BLANK_DIGIT;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      seg_q        <= seg_d;
      sel_q        <= sel_d;
      frame_done_q <= frame_done_d;
      for (int i = 0; i < DIGITS; i++) digits_q[i] <= digits_d[i];
    end
  end

  assign seg        = seg_q;
  assign sel        = sel_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display (DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2): per-cycle
// reference model, directed vector table, hand-written corner sequences and random ops.
module tb_seg_scan_display;

  localparam int DIGITS       = 4;
  localparam int SCAN_DIV     = 8;
  localparam int BLANK_CYCLES = 2;
  localparam int FRAME        = SCAN_DIV * DIGITS;

  logic        clk      = 1'b0;
  logic        clear_n  = 1'b0;
  logic        blank_en = 1'b0;
  logic [7:0]  seg;
  logic [3:0]  sel;
  logic        frame_done;

  seg_scan_if #(.DIGITS(DIGITS)) bus ();

  seg_scan_display #(
    .DIGITS         (DIGITS),
    .SCAN_DIV       (SCAN_DIV),
    .BLANK_CYCLES   (BLANK_CYCLES),
    .SEG_ACTIVE_LOW (1),
    .SEL_ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .clear_n    (clear_n),
    .bus        (bus),
    .blank_en   (blank_en),
    .seg        (seg),
    .sel        (sel),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_vec      = 0;
  int n_err      = 0;
  int cyc        = 0;
  int fd_count   = 0;
  int sel0_count = 0;
  logic [3:0] sel_seen = 4'h0;

  logic       m_blank [DIGITS];
  logic       m_dp    [DIGITS];
  logic [3:0] m_val   [DIGITS];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [6:0] glyph_of(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  function automatic bit plain_zero(input int d);
    return m_blank[d] || (m_val[d] == 4'h0 && !m_dp[d]);
  endfunction

  function automatic bit suppressed(input int d);
`ifdef SEG_SCAN_LZB_EN
    if (d == 0) return 1'b0;
    for (int j = d; j < DIGITS; j++) if (!plain_zero(j)) return 1'b0;
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [7:0] model_seg(input int d);
    if (blank_en || m_blank[d] || suppressed(d)) return 8'hFF;
    return ~{m_dp[d], glyph_of(m_val[d])};
  endfunction

  task automatic model_reset();
    cyc = 0;
    for (int i = 0; i < DIGITS; i++) begin
      m_blank[i] = 1'b1; m_dp[i] = 1'b0; m_val[i] = 4'h0;
    end
  endtask

  task automatic model_update();
    if (bus.clr_buf) begin
      for (int i = 0; i < DIGITS; i++) begin
        m_blank[i] = 1'b1; m_dp[i] = 1'b0; m_val[i] = 4'h0;
      end
    end else if (bus.push_en) begin
      for (int i = DIGITS - 1; i > 0; i--) begin
        m_blank[i] = m_blank[i-1]; m_dp[i] = m_dp[i-1]; m_val[i] = m_val[i-1];
      end
      m_blank[0] = 1'b0; m_dp[0] = 1'b0; m_val[0] = bus.push_value;
    end else if (bus.wr_en) begin
      m_blank[bus.wr_index] = 1'b0;
      m_dp[bus.wr_index]    = bus.wr_dp;
      m_val[bus.wr_index]   = bus.wr_value;
    end
  endtask

  task automatic set_idle();
    bus.wr_en = 1'b0; bus.wr_index = '0; bus.wr_value = 4'h0; bus.wr_dp = 1'b0;
    bus.push_en = 1'b0; bus.push_value = 4'h0; bus.clr_buf = 1'b0;
  endtask

  // One clock: outputs after this edge reflect the slot position and buffer before it.
  task automatic step();
    int         pre;
    int         idx;
    logic [7:0] e_seg;
    logic [3:0] e_sel;
    logic       e_fd;
    pre = cyc % SCAN_DIV;
    idx = (cyc / SCAN_DIV) % DIGITS;
    if (pre < BLANK_CYCLES) begin
      e_seg = 8'hFF;
      e_sel = 4'hF;
    end else begin
      e_seg = model_seg(idx);
      e_sel = ~(4'b0001 << idx);
    end
    e_fd = ((cyc + 1) % FRAME) == 0;
    model_update();
    @(posedge clk);
    #1;
    cyc++;
    check("seg", 32'(seg), 32'(e_seg));
    check("sel", 32'(sel), 32'(e_sel));
    check("frame_done", 32'(frame_done), 32'(e_fd));
    if (frame_done) fd_count++;
    if (sel == 4'b1110) sel0_count++;
    sel_seen |= ~sel;
  endtask

  // Steps at least once, then until digit d is lit on the outputs.
  task automatic wait_slot(input int d);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(((cyc - 1) % SCAN_DIV) >= BLANK_CYCLES &&
                 (((cyc - 1) / SCAN_DIV) % DIGITS) == d) && n < 64);
    if (n >= 64) check("wait_slot_timeout", 32'(n), 32'(0));
  endtask

  typedef struct {
    bit         clr;
    bit         push;
    logic [3:0] pv;
    bit         wr;
    logic [1:0] wi;
    logic [3:0] wv;
    bit         wdp;
    int         dig;
    logic [7:0] exp_seg;
  } vec_t;

  vec_t vecs [13];

  initial begin
    vecs[0]  = '{0, 0, 4'h0, 1, 2'd2, 4'h7, 1, 2, 8'h78};
    vecs[1]  = '{0, 0, 4'h0, 0, 2'd0, 4'h0, 0, 1, 8'hFF};
    vecs[2]  = '{1, 0, 4'h0, 0, 2'd0, 4'h0, 0, 2, 8'hFF};
    vecs[3]  = '{0, 1, 4'h1, 0, 2'd0, 4'h0, 0, 0, 8'hF9};
    vecs[4]  = '{0, 1, 4'h2, 0, 2'd0, 4'h0, 0, 1, 8'hF9};
    vecs[5]  = '{0, 1, 4'h3, 0, 2'd0, 4'h0, 0, 0, 8'hB0};
    vecs[6]  = '{0, 1, 4'h4, 0, 2'd0, 4'h0, 0, 3, 8'hF9};
    vecs[7]  = '{0, 1, 4'h5, 0, 2'd0, 4'h0, 0, 3, 8'hA4};
    vecs[8]  = '{0, 0, 4'h0, 1, 2'd0, 4'hE, 0, 0, 8'h86};
    vecs[9]  = '{1, 1, 4'h9, 1, 2'd3, 4'h8, 1, 3, 8'hFF};
    vecs[10] = '{0, 0, 4'h0, 1, 2'd1, 4'hA, 1, 1, 8'h08};
    vecs[11] = '{0, 1, 4'h0, 0, 2'd0, 4'h0, 0, 0, 8'hC0};
    vecs[12] = '{0, 0, 4'h0, 1, 2'd3, 4'hD, 0, 3, 8'hA1};

    set_idle();
    model_reset();

    // Outputs inactive while reset is held.
    #23;
    check("reset_seg", 32'(seg), 32'(8'hFF));
    check("reset_sel", 32'(sel), 32'(4'hF));
    check("reset_frame_done", 32'(frame_done), 32'(0));
    @(negedge clk);
    clear_n = 1'b1;

    // Two full frames of free-running scan.
    fd_count = 0; sel0_count = 0; sel_seen = 4'h0;
    for (int i = 0; i < 2 * FRAME; i++) step();
    check("frame_pulses", 32'(fd_count), 32'(2));
    check("digit0_on_clocks", 32'(sel0_count), 32'(2 * (SCAN_DIV - BLANK_CYCLES)));
    check("all_digits_selected", 32'(sel_seen), 32'(4'hF));

    // Directed vectors: one buffer op, then look at the chosen digit.
    for (int v = 0; v < 13; v++) begin
      bus.clr_buf = vecs[v].clr;  bus.push_en = vecs[v].push; bus.push_value = vecs[v].pv;
      bus.wr_en   = vecs[v].wr;   bus.wr_index = vecs[v].wi;  bus.wr_value = vecs[v].wv;
      bus.wr_dp   = vecs[v].wdp;
      step();
      set_idle();
      wait_slot(vecs[v].dig);
      check($sformatf("vec%0d_seg", v), 32'(seg), 32'(vecs[v].exp_seg));
    end

    // Zeros ahead of a digit, then forced blanking.
    bus.clr_buf = 1'b1; step(); set_idle();
    bus.push_en = 1'b1;
    bus.push_value = 4'h0; step();
    bus.push_value = 4'h0; step();
    bus.push_value = 4'h4; step();
    set_idle();
    wait_slot(0);
    check("lz_digit0", 32'(seg), 32'(8'h99));
`ifdef SEG_SCAN_LZB_EN
    wait_slot(1); check("lz_digit1", 32'(seg), 32'(8'hFF));
    wait_slot(2); check("lz_digit2", 32'(seg), 32'(8'hFF));
`else
    wait_slot(1); check("zero_digit1", 32'(seg), 32'(8'hC0));
    wait_slot(2); check("zero_digit2", 32'(seg), 32'(8'hC0));
`endif
    blank_en = 1'b1;
    sel_seen = 4'h0;
    for (int i = 0; i < FRAME; i++) step();
    check("blank_sel_scans", 32'(sel_seen), 32'(4'hF));
    wait_slot(0);
    check("blank_digit0", 32'(seg), 32'(8'hFF));
    blank_en = 1'b0;

    // Random buffer traffic against the model.
    for (int i = 0; i < 800; i++) begin
      bus.clr_buf    = ($urandom_range(0, 31) == 0);
      bus.push_en    = ($urandom_range(0, 3) == 0);
      bus.push_value = 4'($urandom_range(0, 15));
      bus.wr_en      = ($urandom_range(0, 2) == 0);
      bus.wr_index   = 2'($urandom_range(0, 3));
      bus.wr_value   = 4'($urandom_range(0, 15));
      bus.wr_dp      = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) blank_en = ~blank_en;
      step();
    end
    set_idle();
    blank_en = 1'b0;

    // Asynchronous reset mid-frame at prescaler 5, index 2.
    for (int n = 0; n < 64 && !((cyc % SCAN_DIV) == 5 && ((cyc / SCAN_DIV) % DIGITS) == 2); n++)
      step();
    check("async_setup_reached", 32'((cyc % SCAN_DIV) == 5 && ((cyc / SCAN_DIV) % DIGITS) == 2), 32'(1));
    #2;
    clear_n = 1'b0;
    #1;
    check("async_seg", 32'(seg), 32'(8'hFF));
    check("async_sel", 32'(sel), 32'(4'hF));
    check("async_frame_done", 32'(frame_done), 32'(0));
    @(negedge clk);
    clear_n = 1'b1;
    model_reset();
    wait_slot(0);
    check("restart_sel", 32'(sel), 32'(4'b1110));
    check("restart_cycle", 32'(cyc), 32'(BLANK_CYCLES + 1));
    for (int i = 0; i < FRAME; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
